uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter byte stream between NUM_REQ requesters, for example the ALU result path and a status/echo path.
- Round-robin arbitration with packet locking: a grant is held until the owner's byte flagged last has been accepted.
- A watchdog revokes a grant held by a stalled requester.
- Sits between the command/ALU logic and the UART TX serializer, in the PLL clock domain.

---
 rtl/uart_arb_pkg.sv | 16 +
 rtl/uart_rr_picker.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX arbiter: FSM states, byte width and
// the watchdog period derived from the PLL clock.
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DATA_W_DEFAULT = 8;

    localparam int CLK_FREQ_HZ            = 27_750_000;
    localparam int WATCHDOG_MS            = 10;
    localparam int TIMEOUT_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * WATCHDOG_MS;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// ascending and wrapping, returned as a one-hot grant plus its index.
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] k;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            k = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX byte stream between NUM_REQ requesters with round-robin
// arbitration, packet locking until the last byte, and a stall watchdog.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_W         = DATA_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      tx_valid_o,
    output logic [DATA_W-1:0]         tx_data_o,
    input  logic                      tx_ready_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  owner_idx;
    logic [IDX_W-1:0]  next_ptr;
    logic [WD_W-1:0]   wdog;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              owner_valid;
    logic              owner_last;
    logic [DATA_W-1:0] owner_data;
    logic              out_free;
    logic              accept;
    logic              packet_done;
    logic              wd_fire;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req_valid_i),
        .rr_ptr (rr_ptr),
        .gnt    (pick_gnt),
        .idx    (pick_idx)
    );

    // grant_o is one-hot on the owner, so masking with it selects the owner's lanes.
    always_comb begin
        owner_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_o[k]) begin
                owner_data = owner_data | req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign owner_valid = |(req_valid_i & grant_o);
    assign owner_last  = |(req_last_i & grant_o);

    // Handshake: a byte moves on any cycle where both valid and ready are high;
    // the owner's ready follows the output register being empty or draining.
    assign out_free    = !tx_valid_o || tx_ready_i;
    assign req_ready_o = (state == SEND && out_free) ? grant_o : '0;
    assign accept      = (state == SEND) && owner_valid && out_free;
    assign packet_done = accept && owner_last;
    assign wd_fire     = (TIMEOUT_CYCLES > 0) && (state == SEND) && !owner_valid && (wdog == WD_LAST);
    assign next_ptr    = (owner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;
    assign busy_o      = (state == SEND) || tx_valid_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|req_valid_i) next_state = SEND;
            SEND:    if (packet_done || wd_fire) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_o   <= '0;
            owner_idx <= '0;
            rr_ptr    <= '0;
            wdog      <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= wd_fire;
            if (state == IDLE) begin
                wdog <= '0;
                if (|req_valid_i) begin
                    grant_o   <= pick_gnt;
                    owner_idx <= pick_idx;
                end
            end else if (packet_done || wd_fire) begin
                grant_o <= '0;
                rr_ptr  <= next_ptr;
                wdog    <= '0;
            end else if (accept) begin
                wdog <= '0;
            end else if (!owner_valid && TIMEOUT_CYCLES > 0) begin
                wdog <= wdog + 1'b1;
            end
        end
    end

    // A revoked grant does not flush the output register; it drains normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
        end else if (accept) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= owner_data;
        end else if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two requesters, watchdog shortened to 8 cycles.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 8;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_last = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready = 1'b1;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
    logic                      timeout;

    int tests_run = 0;
    int tests_failed = 0;

    logic [1:0] t2_g [9];
    logic       t2_v [9];
    logic [7:0] t2_d [9];

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .grant_o     (grant),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL tb_time_limit: simulation ran past 100000 time units");
        $fatal(1);
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic k, input logic v, input logic [7:0] d, input logic l);
        req_valid[k]             = v;
        req_data[{k, 3'b000} +: 8] = d;
        req_last[k]              = l;
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_reset();
        reset_dut();
        tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL rst_grant: got %b want 00", grant); end
        tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL rst_timeout: got %b want 0", timeout); end
        tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL rst_ready: got %b want 00", req_ready); end
        rst_n = 1'b1;
        step();
        tests_run++; if (grant !== 2'b00 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_idle_after_release: grant %b busy %b want 00/0", grant, busy); end
    endtask

    task automatic test_single_packet();
        reset_dut();
        rst_n = 1'b1;                       // c0
        set_req(1'b0, 1'b1, 8'h41, 1'b0);
        #1;
        tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL sp_grant_c0: got %b want 00", grant); end
        tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL sp_ready_idle: got %b want 00", req_ready); end
        step();                             // c1
        tests_run++; if (grant !== 2'b01) begin tests_failed++; $display("FAIL sp_grant_c1: got %b want 01", grant); end
        tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL sp_ready_c1: got %b want 01", req_ready); end
        step();                             // c2
        tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin tests_failed++; $display("FAIL sp_byte0: got v%b %h want v1 41", tx_valid, tx_data); end
        set_req(1'b0, 1'b1, 8'h42, 1'b0);
        step();                             // c3
        tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin tests_failed++; $display("FAIL sp_byte1: got v%b %h want v1 42", tx_valid, tx_data); end
        set_req(1'b0, 1'b1, 8'h43, 1'b1);
        step();                             // c4
        tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h43) begin tests_failed++; $display("FAIL sp_byte2: got v%b %h want v1 43", tx_valid, tx_data); end
        tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL sp_grant_released: got %b want 00", grant); end
        set_req(1'b0, 1'b1, 8'h66, 1'b1);
        set_req(1'b1, 1'b1, 8'h55, 1'b1);
        step();                             // c5: rr_ptr advanced to 1
        tests_run++; if (grant !== 2'b10) begin tests_failed++; $display("FAIL sp_rr_ptr_next: got %b want 10", grant); end
        step();                             // c6
        tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin tests_failed++; $display("FAIL sp_req1_byte: got v%b %h want v1 55", tx_valid, tx_data); end
        step();                             // c7: rr_ptr wrapped to 0
        tests_run++; if (grant !== 2'b01) begin tests_failed++; $display("FAIL sp_rr_wrap: got %b want 01", grant); end
        step();                             // c8
        tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h66) begin tests_failed++; $display("FAIL sp_req0_byte: got v%b %h want v1 66", tx_valid, tx_data); end
        req_valid = '0;
        step();
    endtask

    task automatic test_back_to_back();
        t2_g[1] = 2'b01; t2_v[1] = 1'b0; t2_d[1] = 8'h00;
        t2_g[2] = 2'b00; t2_v[2] = 1'b1; t2_d[2] = 8'hA0;
        t2_g[3] = 2'b10; t2_v[3] = 1'b0; t2_d[3] = 8'h00;
        t2_g[4] = 2'b00; t2_v[4] = 1'b1; t2_d[4] = 8'hB1;
        t2_g[5] = 2'b01; t2_v[5] = 1'b0; t2_d[5] = 8'h00;
        t2_g[6] = 2'b00; t2_v[6] = 1'b1; t2_d[6] = 8'hA0;
        t2_g[7] = 2'b10; t2_v[7] = 1'b0; t2_d[7] = 8'h00;
        t2_g[8] = 2'b00; t2_v[8] = 1'b1; t2_d[8] = 8'hB1;
        reset_dut();
        set_req(1'b0, 1'b1, 8'hA0, 1'b1);
        set_req(1'b1, 1'b1, 8'hB1, 1'b1);
        rst_n = 1'b1;                       // c0
        for (int c = 1; c <= 8; c++) begin
            step();
            tests_run++; if (grant !== t2_g[c]) begin tests_failed++; $display("FAIL b2b_grant_c%0d: got %b want %b", c, grant, t2_g[c]); end
            tests_run++; if (tx_valid !== t2_v[c]) begin tests_failed++; $display("FAIL b2b_valid_c%0d: got %b want %b", c, tx_valid, t2_v[c]); end
            if (t2_v[c]) begin
                tests_run++; if (tx_data !== t2_d[c]) begin tests_failed++; $display("FAIL b2b_data_c%0d: got %h want %h", c, tx_data, t2_d[c]); end
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_stall();
        reset_dut();
        tx_ready = 1'b0;
        set_req(1'b1, 1'b1, 8'h10, 1'b0);
        rst_n = 1'b1;                       // c0
        step();                             // c1
        tests_run++; if (grant !== 2'b10) begin tests_failed++; $display("FAIL st_grant: got %b want 10", grant); end
        tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL st_ready_empty: got %b want 10", req_ready); end
        step();                             // c2
        for (int i = 0; i < 9; i++) begin   // c2..c10, serializer stalled until c10
            if (i == 0) begin
                set_req(1'b1, 1'b1, 8'h11, 1'b1);
                set_req(1'b0, 1'b1, 8'h77, 1'b1);
            end
            if (i == 8) tx_ready = 1'b1;
            #1;
            tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin tests_failed++; $display("FAIL st_hold_%0d: got v%b %h want v1 10", i, tx_valid, tx_data); end
            tests_run++; if (req_ready !== ((i == 8) ? 2'b10 : 2'b00)) begin tests_failed++; $display("FAIL st_ready_%0d: got %b want %b", i, req_ready, (i == 8) ? 2'b10 : 2'b00); end
            tests_run++; if (grant !== 2'b10 || timeout !== 1'b0) begin tests_failed++; $display("FAIL st_grant_to_%0d: got %b/%b want 10/0", i, grant, timeout); end
            step();
        end
        // c11
        tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin tests_failed++; $display("FAIL st_second_byte: got v%b %h want v1 11", tx_valid, tx_data); end
        tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL st_released: got %b want 00", grant); end
        set_req(1'b1, 1'b0, 8'h00, 1'b0);
        step();                             // c12
        tests_run++; if (grant !== 2'b01 || req_ready !== 2'b01) begin tests_failed++; $display("FAIL st_next_owner: got %b/%b want 01/01", grant, req_ready); end
        step();                             // c13
        tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin tests_failed++; $display("FAIL st_req0_byte: got v%b %h want v1 77", tx_valid, tx_data); end
        set_req(1'b0, 1'b0, 8'h00, 1'b0);
        step();
    endtask

    task automatic test_timeout();
        reset_dut();
        set_req(1'b0, 1'b1, 8'h5A, 1'b0);
        rst_n = 1'b1;                       // c0
        step();                             // c1: byte accepted at the end of this cycle
        tests_run++; if (grant !== 2'b01) begin tests_failed++; $display("FAIL to_grant: got %b want 01", grant); end
        step();                             // c2
        tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin tests_failed++; $display("FAIL to_byte: got v%b %h want v1 5a", tx_valid, tx_data); end
        set_req(1'b0, 1'b0, 8'h00, 1'b0);
        set_req(1'b1, 1'b1, 8'hC3, 1'b1);
        #1;
        for (int i = 0; i < 8; i++) begin   // c2..c9
            tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL to_early_%0d: got %b want 0", i, timeout); end
            tests_run++; if (grant !== 2'b01 || busy !== 1'b1 || req_ready !== 2'b01) begin tests_failed++; $display("FAIL to_held_%0d: grant %b busy %b ready %b want 01/1/01", i, grant, busy, req_ready); end
            step();
        end
        // c10: eighth edge after the accepting edge
        tests_run++; if (timeout !== 1'b1) begin tests_failed++; $display("FAIL to_pulse: got %b want 1", timeout); end
        tests_run++; if (grant !== 2'b00 || busy !== 1'b0 || tx_valid !== 1'b0) begin tests_failed++; $display("FAIL to_revoked: grant %b busy %b valid %b want 00/0/0", grant, busy, tx_valid); end
        step();                             // c11
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL to_pulse_width: got %b want 0", timeout); end
        tests_run++; if (grant !== 2'b10) begin tests_failed++; $display("FAIL to_next_grant: got %b want 10", grant); end
        step();                             // c12
        tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'hC3) begin tests_failed++; $display("FAIL to_req1_byte: got v%b %h want v1 c3", tx_valid, tx_data); end
        set_req(1'b1, 1'b0, 8'h00, 1'b0);
        step();
    endtask

    task automatic test_reset_mid_packet();
        reset_dut();
        tx_ready = 1'b0;
        set_req(1'b1, 1'b1, 8'h20, 1'b0);
        rst_n = 1'b1;                       // c0
        step();                             // c1
        tests_run++; if (grant !== 2'b10) begin tests_failed++; $display("FAIL rm_grant: got %b want 10", grant); end
        step();                             // c2
        tests_run++; if (tx_valid !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL rm_loaded: valid %b busy %b want 1/1", tx_valid, busy); end
        set_req(1'b0, 1'b1, 8'h30, 1'b1);
        rst_n = 1'b0;
        #1;
        tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_async_valid: got %b want 0", tx_valid); end
        tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL rm_async_grant: got %b want 00", grant); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rm_async_busy: got %b want 0", busy); end
        step();
        tx_ready = 1'b1;
        rst_n = 1'b1;                       // c0
        step();                             // c1
        tests_run++; if (grant !== 2'b01) begin tests_failed++; $display("FAIL rm_lowest_first: got %b want 01", grant); end
        step();                             // c2
        tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h30) begin tests_failed++; $display("FAIL rm_first_byte: got v%b %h want v1 30", tx_valid, tx_data); end
        req_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
